// File: rtl/alu_seq_pkg.sv
// Shared types and op decode for the ALU operation sequencer.
package alu_seq_pkg;

  // {funct7[5], funct3} op codes
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SHIFT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic invert_a;
    logic invert_b;
    logic carry_in;
    logic or_en;
    logic flood_carry;
  } alu_ctrl_t;

  // ALU control lines for an op; funct7[5] only matters for ADD/SUB.
  // Shift ops return all-zero (ADD), which is what SLL doubling and the
  // shamt=0 pass-through need.
  function automatic alu_ctrl_t op_to_ctrl(input logic [3:0] op);
    alu_ctrl_t c;
    c = '0;
    case (op[2:0])
      OP_ADD[2:0]: begin
        c.invert_b = op[3];
        c.carry_in = op[3];
      end
      OP_SLT[2:0], OP_SLTU[2:0]: begin
        c.invert_b = 1'b1;
        c.carry_in = 1'b1;
      end
      OP_XOR[2:0]: begin
        c.invert_b    = 1'b1;
        c.flood_carry = 1'b1;
      end
      OP_OR[2:0]: c.or_en = 1'b1;
      OP_AND[2:0]: begin
        c.invert_a    = 1'b1;
        c.invert_b    = 1'b1;
        c.or_en       = 1'b1;
        c.flood_carry = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational op -> ALU control decode, also used by the microcode decoder.
module alu_ctrl_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  output alu_ctrl_t  ctrl
);

  assign ctrl = op_to_ctrl(op);

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one RV32 ALU op through an external ripple-carry ALU; shifts
// run one bit per cycle. Result returned over a valid/ready handshake.
module alu_sequencer #(
  parameter int width      = 32,
  parameter int ShamtWidth = 5
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [3:0]       ReqOp,
  input  logic [width-1:0] ReqA,
  input  logic [width-1:0] ReqB,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [width-1:0] RspResult,
  output logic [width-1:0] AluA,
  output logic [width-1:0] AluB,
  output logic             AluCarryIn,
  output logic             AluOr,
  output logic             AluFloodCarry,
  output logic             AluInvertA,
  output logic             AluInvertB,
  input  logic             AluCarryOut,
  input  logic [width-1:0] AluResult
);
  import alu_seq_pkg::*;

  state_t                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [width-1:0]      a_q, a_d, b_q, b_d;
  logic [width-1:0]      work_q, work_d;
  logic [ShamtWidth-1:0] cnt_q, cnt_d;
  logic [width-1:0]      rsp_result_q, rsp_result_d;

  alu_ctrl_t             op_ctrl;
  alu_ctrl_t             alu_ctrl;
  logic                  op_is_shift;
  logic                  op_is_sll;
  logic                  req_is_shift;
  logic [ShamtWidth-1:0] req_shamt;
  logic [width-1:0]      shift_val;
  logic [width-1:0]      exec_result;
  logic                  slt_bit;

  alu_ctrl_decode u_ctrl_decode (
    .op   (op_q),
    .ctrl (op_ctrl)
  );

  assign op_is_shift  = (op_q[1:0] == 2'b01);
  assign op_is_sll    = (op_q[2:0] == OP_SLL[2:0]);
  assign req_is_shift = (ReqOp[1:0] == 2'b01);
  assign req_shamt    = ReqB[ShamtWidth-1:0];

  // Drive the ALU only while it is in use; operands come from latched state
  always_comb begin
    AluA     = '0;
    AluB     = '0;
    alu_ctrl = '0;
    case (state_q)
      ST_EXEC: begin
        AluA     = a_q;
        AluB     = op_is_shift ? '0 : b_q;
        alu_ctrl = op_ctrl;
      end
      ST_SHIFT: begin
        if (op_is_sll) begin
          AluA = work_q;
          AluB = work_q;
        end
      end
      default: ;
    endcase
  end

  assign AluInvertA    = alu_ctrl.invert_a;
  assign AluInvertB    = alu_ctrl.invert_b;
  assign AluCarryIn    = alu_ctrl.carry_in;
  assign AluOr         = alu_ctrl.or_en;
  assign AluFloodCarry = alu_ctrl.flood_carry;

  // Per-op result: SLT/SLTU come from the subtract carry-out, rest from the ALU
  always_comb begin
    slt_bit = (a_q[width-1] != b_q[width-1]) ? a_q[width-1] : ~AluCarryOut;
    case (op_q[2:0])
      OP_SLT[2:0]:  exec_result = {{(width-1){1'b0}}, slt_bit};
      OP_SLTU[2:0]: exec_result = {{(width-1){1'b0}}, ~AluCarryOut};
      default:      exec_result = AluResult;
    endcase
    shift_val = op_is_sll ? AluResult
                          : {op_q[3] & work_q[width-1], work_q[width-1:1]};
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    work_d       = work_q;
    cnt_d        = cnt_q;
    rsp_result_d = rsp_result_q;
    case (state_q)
      ST_IDLE: begin
        if (ReqValid) begin
          op_d = ReqOp;
          a_d  = ReqA;
          b_d  = ReqB;
          if (req_is_shift && (req_shamt != '0)) begin
            work_d  = ReqA;
            cnt_d   = req_shamt;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        rsp_result_d = exec_result;
        state_d      = ST_DONE;
      end
      ST_SHIFT: begin
        work_d = shift_val;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == ShamtWidth'(1)) begin
          rsp_result_d = shift_val;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        if (RspReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any op in flight
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      work_q       <= '0;
      cnt_q        <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      work_q       <= work_d;
      cnt_q        <= cnt_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign ReqReady  = (state_q == ST_IDLE);
  assign RspValid  = (state_q == ST_DONE);
  assign RspResult = rsp_result_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: ALU model in the loop, scoreboard of expected
// results and latencies, directed cases followed by random ops.
module tb_alu_sequencer;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic [3:0]  ReqOp = '0;
  logic [31:0] ReqA = '0;
  logic [31:0] ReqB = '0;
  logic        RspValid;
  logic        RspReady = 1'b1;
  logic [31:0] RspResult;
  logic [31:0] AluA, AluB;
  logic        AluCarryIn, AluOr, AluFloodCarry, AluInvertA, AluInvertB;
  logic        AluCarryOut;
  logic [31:0] AluResult;

  alu_sequencer #(.width(32), .ShamtWidth(5)) dut (
    .Clock(Clock), .ResetN(ResetN),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
    .ReqA(ReqA), .ReqB(ReqB),
    .RspValid(RspValid), .RspReady(RspReady), .RspResult(RspResult),
    .AluA(AluA), .AluB(AluB),
    .AluCarryIn(AluCarryIn), .AluOr(AluOr), .AluFloodCarry(AluFloodCarry),
    .AluInvertA(AluInvertA), .AluInvertB(AluInvertB),
    .AluCarryOut(AluCarryOut), .AluResult(AluResult)
  );

  always #5 Clock = ~Clock;

  // Ripple-carry ALU: optional operand inversion, sum with carry-in, OR mode,
  // and flood-carry (every bit sees carry 1, which inverts the bit result).
  logic [31:0] alu_ia, alu_ib;
  logic [32:0] alu_sum;
  always_comb begin
    alu_ia  = AluInvertA ? ~AluA : AluA;
    alu_ib  = AluInvertB ? ~AluB : AluB;
    alu_sum = {1'b0, alu_ia} + {1'b0, alu_ib} + {32'b0, AluCarryIn};
    if (AluOr)              AluResult = (alu_ia | alu_ib) ^ {32{AluFloodCarry}};
    else if (AluFloodCarry) AluResult = ~(alu_ia ^ alu_ib);
    else                    AluResult = alu_sum[31:0];
    AluCarryOut = alu_sum[32];
  end

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model straight from the instruction semantics
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int unsigned sh;
    sh = b[4:0];
    case (op[2:0])
      3'b000:  return op[3] ? a - b : a + b;
      3'b001:  return a << sh;
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return (a < b) ? 32'd1 : 32'd0;
      3'b100:  return a ^ b;
      3'b101:  return op[3] ? $unsigned($signed(a) >>> sh) : (a >> sh);
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
    if (op[1:0] == 2'b01 && b[4:0] != 5'd0) return 1 + int'(b[4:0]);
    return 2;
  endfunction

  typedef struct {
    logic [31:0] result;
    int          acc_cyc;
    int          latency;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: on each new response pop the expectation; while stalled the
  // response must hold and no new request may be accepted.
  logic        prev_valid = 1'b0;
  logic [31:0] held_exp = '0;
  always @(negedge Clock) begin
    exp_t e;
    if (!ResetN) begin
      prev_valid = 1'b0;
    end else begin
      if (RspValid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_result"}, RspResult, e.result);
          check({e.name, "_latency"}, 32'(cyc - e.acc_cyc), 32'(e.latency));
          check({e.name, "_done_ctrl"},
                {27'd0, AluInvertA, AluInvertB, AluCarryIn, AluOr, AluFloodCarry}, 32'd0);
          held_exp = e.result;
        end
      end else if (RspValid && prev_valid) begin
        check("hold_result", RspResult, held_exp);
        check("hold_reqready", {31'd0, ReqReady}, 32'd0);
      end
      prev_valid = RspValid;
    end
  end

  task automatic wait_ready();
    int t;
    t = 0;
    while (!ReqReady && t < 200) begin
      @(negedge Clock);
      t++;
    end
    if (!ReqReady) check("reqready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit expect_rsp);
    exp_t e;
    @(negedge Clock);
    wait_ready();
    ReqValid = 1'b1;
    ReqOp    = op;
    ReqA     = a;
    ReqB     = b;
    if (expect_rsp) begin
      e.result  = ref_result(op, a, b);
      e.acc_cyc = cyc;
      e.latency = ref_latency(op, b);
      e.name    = name;
      exp_q.push_back(e);
    end
    @(negedge Clock);
    ReqValid = 1'b0;
    ReqA     = $urandom;
    ReqB     = $urandom;
    ReqOp    = 4'($urandom);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_reqready"}, {31'd0, ReqReady}, 32'd1);
    check({name, "_rspvalid"}, {31'd0, RspValid}, 32'd0);
    check({name, "_rspresult"}, RspResult, 32'd0);
    check({name, "_alua"}, AluA, 32'd0);
    check({name, "_alub"}, AluB, 32'd0);
    check({name, "_ctrl"},
          {27'd0, AluInvertA, AluInvertB, AluCarryIn, AluOr, AluFloodCarry}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    logic [3:0] rop;
    logic [31:0] ra, rb;

    repeat (2) @(negedge Clock);
    check_reset_outputs("in_reset");
    ResetN = 1'b1;
    @(negedge Clock);
    check_reset_outputs("after_reset");

    issue("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1, 1'b1);
    issue("sub",      4'b1000, 32'd5, 32'd7, 1'b1);
    issue("slt",      4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b1);
    issue("sltu",     4'b0011, 32'hFFFF_FFFF, 32'd1, 1'b1);
    issue("sll31",    4'b0001, 32'd1, 32'd31, 1'b1);
    issue("sll0",     4'b0001, 32'h1234_5678, 32'h0000_0020, 1'b1);
    issue("sra4",     4'b1101, 32'h8000_0000, 32'd4, 1'b1);
    issue("srl4",     4'b0101, 32'h8000_0000, 32'd4, 1'b1);
    issue("or",       4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
    issue("xor",      4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);

    // AND with the consumer stalling for 5 cycles
    @(negedge Clock);
    wait_ready();
    RspReady = 1'b0;
    issue("and_stall", 4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
    t = 0;
    while (!RspValid && t < 100) begin
      @(negedge Clock);
      t++;
    end
    if (!RspValid) check("stall_rsp_timeout", 32'd0, 32'd1);
    repeat (5) @(negedge Clock);
    RspReady = 1'b1;

    // Reset in the middle of a long SRL: no response may come out
    issue("srl20_abort", 4'b0101, 32'hDEAD_BEEF, 32'd20, 1'b0);
    repeat (4) @(negedge Clock);
    ResetN = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge Clock);
    ResetN = 1'b1;
    #1;
    check("post_reset_reqready", {31'd0, ReqReady}, 32'd1);
    repeat (25) @(negedge Clock);
    check("abort_no_rsp", {31'd0, RspValid}, 32'd0);
    issue("add_after_reset", 4'b0000, 32'h0000_1234, 32'h0000_4321, 1'b1);

    // Random ops, any 4-bit op code
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      issue("random", rop, ra, rb, 1'b1);
    end

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge Clock);
      t++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge Clock);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
